// File: rtl/alu_bist_pkg.sv
// Shared types and helpers for the ALU self-test controller.
// Latency: n/a (types, constants and a combinational step function).
// Backpressure: n/a.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } bist_state_e;

  // x^32 + x^22 + x^2 + x + 1, Galois right-shift form
  localparam logic [31:0] POLY32 = 32'h8020_0003;
  // Decorrelates operand B from operand A
  localparam logic [31:0] B_XOR  = 32'hA5A5_A5A5;

  // One Galois step, used by both the operand LFSR and the MISR
  function automatic logic [31:0] step32(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY32 : 32'h0);
  endfunction

endpackage

// File: rtl/alu_bist_if.sv
// Bundle between the self-test controller and the ALU it exercises.
// Latency: none, wires only.
// Backpressure: none; the ALU is combinational and always accepts.
interface alu_bist_if;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_overflow;
  logic        alu_zero;
  logic        alu_negative;

  // Controller side: drives operands, observes response
  modport master (
    output alu_a, alu_b, alu_ctrl,
    input  alu_result, alu_carry, alu_overflow, alu_zero, alu_negative
  );

  // ALU side: consumes operands, returns response
  modport slave (
    input  alu_a, alu_b, alu_ctrl,
    output alu_result, alu_carry, alu_overflow, alu_zero, alu_negative
  );
endinterface

// File: rtl/alu_bist_misr.sv
// 32-bit multiple-input signature register compacting the ALU responses.
// Latency: one cycle per captured word; sig reflects the word captured on the previous edge.
// Backpressure: none; captures every cycle en is high.
module alu_bist_misr
  import alu_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] sig
);

  // Clear wins over capture so a fresh test never inherits old state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= 32'h0;
    end else if (clr) begin
      sig <= 32'h0;
    end else if (en) begin
      sig <= step32(sig) ^ d;
    end
  end

endmodule

// File: rtl/alu_bist_ctrl.sv
// ALU built-in self-test: sweeps op codes with LFSR operands, compacts responses, checks a golden signature.
// Latency: NUM_VECTORS*NUM_OPS+1 cycles from the accepted start edge to done.
// Backpressure: none; one vector per cycle, start ignored while busy, abort cancels at once.
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 64,
  parameter int unsigned NUM_OPS     = 8,
  parameter logic [31:0] LFSR_SEED   = 32'h0000_0001,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [31:0]       signature,
  alu_bist_if.master        alu
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] RUN     = ST_RUN;
  localparam logic [1:0] COMPARE = ST_COMPARE;
  localparam logic [1:0] DONE    = ST_DONE;

  // An all-zero seed would lock the LFSR, so substitute 1
  localparam logic [31:0] SEED_EFF = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam int unsigned VW       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [VW-1:0] VLAST  = VW'(NUM_VECTORS - 1);
  localparam logic [2:0]    OLAST  = 3'(NUM_OPS - 1);

  logic [1:0]    state;
  logic [31:0]   lfsr;
  logic [VW-1:0] vidx;
  logic [2:0]    oidx;
  logic [31:0]   sig_q;
  logic          pass_q;
  logic [31:0]   misr_sig;
  logic [31:0]   misr_d;
  logic          accept;
  logic          running;

  assign running = (state == RUN);
  assign accept  = ((state == IDLE) || (state == DONE)) && start && !abort;

  // Sequencer: state, vector/op counters and operand LFSR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lfsr  <= SEED_EFF;
      vidx  <= '0;
      oidx  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (abort) begin
            state <= IDLE;
          end else if (start) begin
            state <= RUN;
            lfsr  <= SEED_EFF;
            vidx  <= '0;
            oidx  <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            // Response to the current vector is captured by the MISR this edge
            lfsr <= step32(lfsr);
            if (vidx == VLAST) begin
              vidx <= '0;
              if (oidx == OLAST) begin
                state <= COMPARE;
              end else begin
                oidx <= oidx + 3'd1;
              end
            end else begin
              vidx <= vidx + 1'b1;
            end
          end
        end
        COMPARE: state <= abort ? IDLE : DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Result registers: cleared on a new test or abort, loaded once in COMPARE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q  <= 32'h0;
      pass_q <= 1'b0;
    end else if (accept || abort) begin
      sig_q  <= 32'h0;
      pass_q <= 1'b0;
    end else if (state == COMPARE) begin
      sig_q  <= misr_sig;
      pass_q <= (misr_sig == GOLDEN_SIG);
    end
  end

  // Flags fold into the top nibble of the compacted word
  assign misr_d = alu.alu_result ^
                  {alu.alu_carry, alu.alu_overflow, alu.alu_zero, alu.alu_negative, 28'b0};

  alu_bist_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (running),
    .d     (misr_d),
    .sig   (misr_sig)
  );

  // Operands are only driven while running so the ALU sees zeros otherwise
  assign alu.alu_a    = running ? lfsr : 32'h0;
  assign alu.alu_b    = running ? ({lfsr[15:0], lfsr[31:16]} ^ B_XOR) : 32'h0;
  assign alu.alu_ctrl = running ? oidx : 3'h0;

  assign busy      = running || (state == COMPARE);
  assign done      = (state == DONE);
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Testbench for alu_bist_ctrl: stubbed single-vector instances plus a full-size instance on a reference ALU.
// Final signatures/pass go through a scoreboard popped on each rising done.
module tb_alu_bist_ctrl;

  typedef struct packed {
    logic [31:0] sig;
    logic        ok;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic abort0 = 1'b0, abort2 = 1'b0;
  logic [31:0] stub_res = 32'h0;

  logic        busy0, done0, pass0;
  logic        busy1, done1, pass1;
  logic        busy2, done2, pass2;
  logic [31:0] sig0, sig1, sig2;
  logic [35:0] r2;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  exp_t q0[$];
  exp_t q2[$];
  logic [31:0] gold;

  always #5 clk = ~clk;

  alu_bist_if if0 ();
  alu_bist_if if1 ();
  alu_bist_if if2 ();

  alu_bist_ctrl #(.NUM_VECTORS(1), .NUM_OPS(1), .LFSR_SEED(32'h1), .GOLDEN_SIG(32'h0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .busy(busy0), .done(done0), .pass(pass0), .signature(sig0), .alu(if0)
  );

  alu_bist_ctrl #(.NUM_VECTORS(1), .NUM_OPS(1), .LFSR_SEED(32'h0), .GOLDEN_SIG(32'h0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .alu(if1)
  );

  alu_bist_ctrl u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .alu(if2)
  );

  // Stub responders
  assign if0.alu_result   = stub_res;
  assign if0.alu_carry    = 1'b0;
  assign if0.alu_overflow = 1'b0;
  assign if0.alu_zero     = 1'b0;
  assign if0.alu_negative = 1'b0;
  assign if1.alu_result   = 32'h0;
  assign if1.alu_carry    = 1'b0;
  assign if1.alu_overflow = 1'b0;
  assign if1.alu_zero     = 1'b0;
  assign if1.alu_negative = 1'b0;

  // Reference ALU: {carry, overflow, zero, negative, result}
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] res;
    logic c, v;
    s = 33'h0; res = 32'h0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b}; res = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (res[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; res = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (res[31] != a[31]);
      end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = {31'b0, $signed(a) < $signed(b)};
      3'd6: res = a << b[4:0];
      default: res = a >> b[4:0];
    endcase
    return {c, v, (res == 32'h0), res[31], res};
  endfunction

  always_comb r2 = alu_f(if2.alu_a, if2.alu_b, if2.alu_ctrl);
  assign if2.alu_result   = r2[31:0];
  assign if2.alu_carry    = r2[35];
  assign if2.alu_overflow = r2[34];
  assign if2.alu_zero     = r2[33];
  assign if2.alu_negative = r2[32];

  function automatic logic [31:0] tb_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Algorithm-level signature of a default-size run (64 vectors x 8 ops)
  function automatic logic [31:0] model_sig(input logic [31:0] seed);
    logic [31:0] l, m, b;
    logic [35:0] r;
    l = (seed == 32'h0) ? 32'h1 : seed;
    m = 32'h0;
    for (int op = 0; op < 8; op++) begin
      for (int v = 0; v < 64; v++) begin
        b = {l[15:0], l[31:16]} ^ 32'hA5A5_A5A5;
        r = alu_f(l, b, op[2:0]);
        m = tb_step(m) ^ r[31:0] ^ {r[35:32], 28'h0};
        l = tb_step(l);
      end
    end
    return m;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop expected result whenever a DUT raises done
  initial begin
    exp_t e;
    forever begin
      @(posedge done0);
      #1;
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL u0_unexpected_done: got done=1, expected no completion");
      end else begin
        e = q0.pop_front();
        check("u0_signature", sig0, e.sig);
        check("u0_pass", {31'b0, pass0}, {31'b0, e.ok});
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge done2);
      #1;
      if (q2.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL u2_unexpected_done: got done=1, expected no completion");
      end else begin
        e = q2.pop_front();
        check("u2_signature", sig2, e.sig);
        check("u2_pass", {31'b0, pass2}, {31'b0, e.ok});
      end
    end
  end

  task automatic wait_done0(input string nm, input int exp_cyc);
    int n = 0;
    while (!done0 && n < 100) begin tick(); n++; end
    check(nm, n, exp_cyc);
  endtask

  // Optionally pulses start mid-run, which must be ignored
  task automatic wait_done2(input string nm, input bit poke);
    int n = 0;
    while (!done2 && n < 2000) begin
      tick(); n++;
      start2 = poke && (n == 10 || n == 300);
    end
    start2 = 1'b0;
    check(nm, n, 513);
  endtask

  task automatic start_u2();
    start2 = 1'b1; tick(); start2 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    gold = model_sig(32'h1);

    // Reset values, with start held during reset
    start0 = 1'b1; start2 = 1'b1;
    repeat (3) tick();
    check("rst_busy0", {31'b0, busy0}, 0);
    check("rst_done0", {31'b0, done0}, 0);
    check("rst_pass0", {31'b0, pass0}, 0);
    check("rst_sig0", sig0, 0);
    check("rst_alu_a2", if2.alu_a, 0);
    check("rst_alu_b2", if2.alu_b, 0);
    check("rst_ctrl2", {29'b0, if2.alu_ctrl}, 0);
    check("rst_busy2", {31'b0, busy2}, 0);
    start0 = 1'b0; start2 = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_idle0", {31'b0, busy0}, 0);
    check("post_rst_idle2", {31'b0, busy2}, 0);

    // Single vector, responder returns 0
    stub_res = 32'h0;
    q0.push_back('{sig: 32'h0, ok: 1'b1});
    start0 = 1'b1; tick(); start0 = 1'b0;
    check("u0_alu_a_e0", if0.alu_a, 32'h1);
    check("u0_alu_b_e0", if0.alu_b, 32'hA5A4_A5A5);
    check("u0_ctrl_e0", {29'b0, if0.alu_ctrl}, 0);
    check("u0_busy_e0", {31'b0, busy0}, 1);
    wait_done0("u0_latency_zero", 2);
    check("u0_busy_done", {31'b0, busy0}, 0);
    check("u0_alu_a_done", if0.alu_a, 0);
    tick();

    // Mismatch: responder returns 1, restart from DONE
    stub_res = 32'h1;
    q0.push_back('{sig: 32'h1, ok: 1'b0});
    start0 = 1'b1; tick(); start0 = 1'b0;
    wait_done0("u0_latency_mismatch", 2);
    tick();

    // Zero seed behaves like seed 1
    start1 = 1'b1; tick(); start1 = 1'b0;
    check("u1_alu_a_zero_seed", if1.alu_a, 32'h1);
    check("u1_alu_b_zero_seed", if1.alu_b, 32'hA5A4_A5A5);
    repeat (2) tick();
    check("u1_done", {31'b0, done1}, 1);
    check("u1_sig", sig1, 32'h0);
    check("u1_pass", {31'b0, pass1}, 1);
    check("u1_busy", {31'b0, busy1}, 0);

    // Abort at cycle 100 of a full run
    start_u2();
    repeat (100) tick();
    abort2 = 1'b1; tick(); abort2 = 1'b0;
    check("u2_abort_busy", {31'b0, busy2}, 0);
    check("u2_abort_done", {31'b0, done2}, 0);
    repeat (5) tick();
    check("u2_abort_done_later", {31'b0, done2}, 0);
    check("u2_abort_alu_a", if2.alu_a, 0);

    // Restart with ignored start pulses, then a second identical run
    q2.push_back('{sig: gold, ok: (gold == 32'h0)});
    start_u2();
    check("u2_ctrl_first", {29'b0, if2.alu_ctrl}, 0);
    wait_done2("u2_latency_run1", 1'b1);
    tick();
    q2.push_back('{sig: gold, ok: (gold == 32'h0)});
    start_u2();
    wait_done2("u2_latency_run2", 1'b0);
    tick();

    // Reset at cycle 200, then a full run
    start_u2();
    repeat (200) tick();
    rst_n = 1'b0;
    #1;
    check("u2_midrst_busy", {31'b0, busy2}, 0);
    check("u2_midrst_alu_a", if2.alu_a, 0);
    check("u2_midrst_sig", sig2, 0);
    #3;
    rst_n = 1'b1;
    tick();
    q2.push_back('{sig: gold, ok: (gold == 32'h0)});
    start_u2();
    wait_done2("u2_latency_after_rst", 1'b0);

    repeat (3) tick();
    check("q0_drained", q0.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
